// File: rtl/sync_ctrl.sv
// SYNC~ handling for a JESD204 transmitter: classifies SYNC~ lows as error reports or sync requests, sequences CGS/ILA.
// Latency: SYNC~ edge reaches the FSM after a 2-flop synchronizer; all outputs are registered state or decodes of it (3 clks input to output).
// Backpressure: none; SYNC~ is a level input and every strobe is consumed the cycle it arrives.
module sync_ctrl #(
  parameter int SYNC_REQ_FRAMES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_clk,
  input  logic       lmfc_clk,
  input  logic       i_sync_n,
  output logic       o_err_reporting,
  output logic       o_sync_request_tx,
  output logic       o_sync_de_assertion,
  output logic       o_cgs_req,
  output logic       o_ila_start,
  output logic [7:0] o_err_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ASSERTED  = 2'd1,
    REQUEST   = 2'd2,
    WAIT_LMFC = 2'd3
  } state_t;

  localparam logic [3:0] REQ_FRAMES = 4'(SYNC_REQ_FRAMES);

  state_t     state_q, state_d;
  logic       sync_meta_q;
  logic       sync_s_q;
  logic       sync_prev_q;
  logic [3:0] frm_cnt_q, frm_cnt_d, frm_cnt_inc;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       ila_start_q, ila_start_d;
  logic       de_assert_q, de_assert_d;

  // Two-flop synchronizer for the asynchronous SYNC~, plus a delayed copy for rise detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_q <= 1'b1;
      sync_s_q    <= 1'b1;
      sync_prev_q <= 1'b1;
    end else begin
      sync_meta_q <= i_sync_n;
      sync_s_q    <= sync_meta_q;
      sync_prev_q <= sync_s_q;
    end
  end

  // Next-state, frame counter, error counter and pulse computation.
  always_comb begin
    state_d     = state_q;
    frm_cnt_d   = 4'd0;
    err_cnt_d   = err_cnt_q;
    ila_start_d = 1'b0;
    // Counter value this cycle would reach if the strobe is taken; saturates at the threshold.
    frm_cnt_inc = (frame_clk && (frm_cnt_q != REQ_FRAMES)) ? frm_cnt_q + 4'd1 : frm_cnt_q;

    case (state_q)
      IDLE: begin
        if (!sync_s_q) state_d = ASSERTED;
      end
      ASSERTED: begin
        // SYNC~ release wins over a simultaneous threshold strobe: it is an error report.
        if (sync_s_q) begin
          state_d = IDLE;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (frm_cnt_inc == REQ_FRAMES) begin
          state_d = REQUEST;
        end else begin
          frm_cnt_d = frm_cnt_inc;
        end
      end
      REQUEST: begin
        if (sync_s_q) state_d = WAIT_LMFC;
      end
      WAIT_LMFC: begin
        // A new SYNC~ low beats a coincident LMFC boundary; ILA is not started.
        if (!sync_s_q) begin
          state_d = ASSERTED;
        end else if (lmfc_clk) begin
          state_d     = IDLE;
          ila_start_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set on the first synchronized-high cycle after a low, held while high, cleared by any low.
    de_assert_d = sync_s_q & (de_assert_q | ~sync_prev_q);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frm_cnt_q   <= 4'd0;
      err_cnt_q   <= 8'd0;
      ila_start_q <= 1'b0;
      de_assert_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frm_cnt_q   <= frm_cnt_d;
      err_cnt_q   <= err_cnt_d;
      ila_start_q <= ila_start_d;
      de_assert_q <= de_assert_d;
    end
  end

  assign o_err_reporting     = (state_q == ASSERTED);
  assign o_sync_request_tx   = (state_q == REQUEST) || (state_q == WAIT_LMFC);
  assign o_cgs_req           = (state_q == REQUEST) || (state_q == WAIT_LMFC);
  assign o_ila_start         = ila_start_q;
  assign o_sync_de_assertion = de_assert_q;
  assign o_err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_sync_ctrl.sv
// Directed self-checking bench for sync_ctrl with the default 6-frame threshold.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
// Every expected value below is hand-derived from the SYNC~ handling rules.
module tb_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_clk;
  logic       lmfc_clk;
  logic       i_sync_n;
  logic       o_err_reporting;
  logic       o_sync_request_tx;
  logic       o_sync_de_assertion;
  logic       o_cgs_req;
  logic       o_ila_start;
  logic [7:0] o_err_cnt;

  int checks = 0;
  int errors = 0;

  sync_ctrl #(.SYNC_REQ_FRAMES(6)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .frame_clk           (frame_clk),
    .lmfc_clk            (lmfc_clk),
    .i_sync_n            (i_sync_n),
    .o_err_reporting     (o_err_reporting),
    .o_sync_request_tx   (o_sync_request_tx),
    .o_sync_de_assertion (o_sync_de_assertion),
    .o_cgs_req           (o_cgs_req),
    .o_ila_start         (o_ila_start),
    .o_err_cnt           (o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame strobe followed by an idle cycle.
  task automatic strobes(input int n);
    for (int k = 0; k < n; k++) begin
      frame_clk = 1'b1;
      tick();
      frame_clk = 1'b0;
      tick();
    end
  endtask

  // Outputs as a packed vector: {err_rep, req_tx, de, cgs, ila}.
  function automatic logic [7:0] flags();
    return {3'b000, o_err_reporting, o_sync_request_tx, o_sync_de_assertion, o_cgs_req, o_ila_start};
  endfunction

  initial begin
    rst       = 1'b1;
    frame_clk = 1'b0;
    lmfc_clk  = 1'b0;
    i_sync_n  = 1'b1;
    tick();
    tick();
    check("reset_flags", flags(), 8'h00);
    check("reset_err_cnt", o_err_cnt, 8'd0);
    rst = 1'b0;
    tick();
    check("idle_flags", flags(), 8'h00);

    // Error report: SYNC~ low for 3 frames then high.
    i_sync_n = 1'b0;
    tick();
    tick();
    check("lat_edge2_err_rep", {7'd0, o_err_reporting}, 8'd0);
    tick();
    check("lat_edge3_err_rep", {7'd0, o_err_reporting}, 8'd1);
    strobes(3);
    check("err3_flags", flags(), 8'h10);
    i_sync_n = 1'b1;
    tick();
    tick();
    check("err3_before_rise", flags(), 8'h10);
    tick();
    check("err3_after_rise", flags(), 8'h04);
    check("err3_cnt", o_err_cnt, 8'd1);

    // Sync request: 6 frames low, then release and wait for LMFC.
    i_sync_n = 1'b0;
    repeat (3) tick();
    check("req_asserted", flags(), 8'h10);
    strobes(5);
    check("req_5_frames", flags(), 8'h10);
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    check("req_6th_frame", flags(), 8'h0A);
    i_sync_n = 1'b1;
    repeat (3) tick();
    check("wait_lmfc_flags", flags(), 8'h0E);
    tick();
    check("wait_lmfc_hold", flags(), 8'h0E);
    lmfc_clk = 1'b1;
    tick();
    lmfc_clk = 1'b0;
    check("ila_pulse", flags(), 8'h05);
    tick();
    check("ila_after", flags(), 8'h04);
    check("req_err_cnt", o_err_cnt, 8'd1);

    // SYNC~ release coincides with the 6th frame strobe: error report wins.
    i_sync_n = 1'b0;
    repeat (3) tick();
    strobes(5);
    i_sync_n = 1'b1;
    tick();
    tick();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    check("race_flags", flags(), 8'h04);
    check("race_err_cnt", o_err_cnt, 8'd2);

    // SYNC~ falls together with lmfc_clk while waiting: back to ASSERTED, no ILA.
    i_sync_n = 1'b0;
    repeat (3) tick();
    strobes(6);
    check("wl_request", flags(), 8'h0A);
    i_sync_n = 1'b1;
    repeat (3) tick();
    check("wl_wait", flags(), 8'h0E);
    i_sync_n = 1'b0;
    tick();
    tick();
    lmfc_clk = 1'b1;
    tick();
    lmfc_clk = 1'b0;
    check("wl_reassert", flags(), 8'h10);
    strobes(5);
    check("wl_cnt_restart_5", flags(), 8'h10);
    strobes(1);
    check("wl_cnt_restart_6", flags(), 8'h0A);
    check("wl_err_cnt", o_err_cnt, 8'd2);

    // Reset pulse while in REQUEST with SYNC~ still low.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_flags", flags(), 8'h00);
    check("rst_err_cnt", o_err_cnt, 8'd0);
    tick();
    check("rst_rel_1", flags(), 8'h00);
    tick();
    check("rst_rel_2", flags(), 8'h00);
    tick();
    check("rst_rel_3", flags(), 8'h10);

    // Error counter saturation.
    i_sync_n = 1'b1;
    repeat (3) tick();
    check("sat_first", o_err_cnt, 8'd1);
    for (int r = 0; r < 254; r++) begin
      i_sync_n = 1'b0;
      repeat (3) tick();
      i_sync_n = 1'b1;
      repeat (3) tick();
    end
    check("sat_255", o_err_cnt, 8'd255);
    i_sync_n = 1'b0;
    repeat (3) tick();
    i_sync_n = 1'b1;
    repeat (3) tick();
    check("sat_256", o_err_cnt, 8'd255);
    check("sat_flags", flags(), 8'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_ctrl.md
SYNC_CTRL -- requirements
Module: sync_ctrl

Interface
REQ-001 SHALL have parameter SYNC_REQ_FRAMES, default 6, legal range 2..15: frame strobes SYNC~ must stay low to count as a sync request rather than an error report.
REQ-002 SHALL have port clk  input  1  device clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port frame_clk  input  1  one-clk frame-boundary strobe.
REQ-005 SHALL have port lmfc_clk  input  1  one-clk LMFC-boundary strobe.
REQ-006 SHALL have port i_sync_n  input  1  raw SYNC~ from receiver, asynchronous, active-low.
REQ-007 SHALL have port o_err_reporting  output  1  high while SYNC~ is low and not yet classified as a sync request.
REQ-008 SHALL have port o_sync_request_tx  output  1  high once SYNC~ is classified as a sync request, until ILA start.
REQ-009 SHALL have port o_sync_de_assertion  output  1  set on SYNC~ low-to-high, cleared when SYNC~ is low.
REQ-010 SHALL have port o_cgs_req  output  1  request for continuous K (code group sync) on the link mux.
REQ-011 SHALL have port o_ila_start  output  1  one-clk pulse: begin ILA after a sync request.
REQ-012 SHALL have port o_err_cnt  output  8  saturating count of completed error reports.

Function
REQ-013 SHALL pass i_sync_n through a 2-flop synchronizer (sync_s); both flops reset to 1.
REQ-014 SHALL implement a 4-state FSM: IDLE, ASSERTED, REQUEST, WAIT_LMFC; the state register updates every clk.
REQ-015 IDLE: sync_s=0 -> ASSERTED; otherwise stay.
REQ-016 ASSERTED: sync_s=1 -> IDLE, and o_err_cnt increments by 1, saturating at 255; else frame counter reaching SYNC_REQ_FRAMES -> REQUEST; else stay.
REQ-017 REQUEST: sync_s=1 -> WAIT_LMFC; otherwise stay.
REQ-018 WAIT_LMFC: sync_s=0 -> ASSERTED with frame counter cleared; else lmfc_clk=1 -> IDLE with o_ila_start pulsed; else stay.
REQ-019 Frame counter: 4-bit, cleared in every state except ASSERTED; in ASSERTED it increments on frame_clk and saturates at SYNC_REQ_FRAMES.
REQ-020 In ASSERTED, sync_s=1 coinciding with the frame_clk that would reach the threshold SHALL go to IDLE as an error report, not to REQUEST.
REQ-021 In WAIT_LMFC, sync_s=0 coinciding with lmfc_clk SHALL go to ASSERTED, with no o_ila_start.
REQ-022 Moore outputs decoded from the state register: o_err_reporting=(ASSERTED), o_sync_request_tx=(REQUEST|WAIT_LMFC), o_cgs_req=(REQUEST|WAIT_LMFC).
REQ-023 o_ila_start SHALL be registered, high exactly one clk, in the cycle the state changes from WAIT_LMFC to IDLE.
REQ-024 o_sync_de_assertion SHALL be registered: set on the clk after sync_s rises; cleared on the clk after sync_s=0.
REQ-025 Latency: i_sync_n falling at edge N gives sync_s=0 after edge N+2 and o_err_reporting=1 after edge N+3.
REQ-026 During an error report, o_err_reporting and o_sync_de_assertion SHALL overlap for 0 cycles; o_err_reporting falls on the same edge o_sync_de_assertion rises.

Reset
REQ-027 rst=1 SHALL force: state IDLE, counter 0, synchronizer flops 1, o_err_cnt 0, o_ila_start 0, o_sync_de_assertion 0, all decoded outputs 0.
REQ-028 rst asserted mid-operation (any state) SHALL take effect on the next clk edge; on rst release the FSM restarts from IDLE with no pulse on o_ila_start.

Verification
REQ-029 SYNC~ low for 3 frame strobes then high (default parameter) -> o_err_reporting high for that interval; o_sync_request_tx never high; o_err_cnt 0->1; o_sync_de_assertion rises.
REQ-030 SYNC~ low for 6 frame strobes -> o_err_reporting falls and o_sync_request_tx/o_cgs_req rise together; SYNC~ high -> o_ila_start pulses one clk on the first lmfc_clk, then o_cgs_req=0; o_err_cnt unchanged.
REQ-031 SYNC~ rises in the same cycle as the 6th frame strobe -> error report: o_err_cnt increments; o_sync_request_tx stays 0.
REQ-032 In WAIT_LMFC, SYNC~ falls in the same cycle as lmfc_clk -> no o_ila_start; o_err_reporting=1; frame counter restarts from 0.
REQ-033 256 error reports -> o_err_cnt=255 after the 255th and stays 255 after the 256th.
REQ-034 rst pulsed for 1 clk while in REQUEST -> all outputs 0 on the next edge; with SYNC~ still low, o_err_reporting returns 3 clks after rst release.
